mgt_01_freg_context_unit: RTL

- Context save/restore engine on the far side of the FP register file's bulk store/load port.
- Save: snapshots all 32 FP registers in one cycle from the register file's bulk output, then streams them to data memory as 32 word writes.
- Restore: reads 32 words from memory into an internal buffer, then drives the bulk load port with a one-cycle load strobe.
- Used by the trap/context-switch logic.

---
 rtl/mgt_01_freg_context_unit_pkg.sv | 25 ++
 rtl/mgt_01_freg_context_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mgt_01_freg_context_unit_pkg.sv
// rtl/mgt_01_freg_context_unit_pkg.sv - shared types and constants for the FP register context engine
// Options: MGT_01_FREG_CTX_FCSR_EN adds the fcsr word to the context area.
package mgt_01_freg_context_unit_pkg;

  localparam int XLEN = 32;
  typedef logic [XLEN-1:0] float_t;

`ifdef MGT_01_FREG_CTX_FCSR_EN
  localparam int FREG_CTX_WORDS = XLEN + 1;
`else
  localparam int FREG_CTX_WORDS = XLEN;
`endif

  localparam int FREG_CTX_FCSR_OFFSET = 128;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAVE_REQ,
    ST_LOAD_REQ,
    ST_LOAD_WAIT,
    ST_COMMIT,
    ST_DONE
  } ctx_state_e;

endpackage

// File: rtl/mgt_01_freg_context_unit.sv
// rtl/mgt_01_freg_context_unit.sv - FP register file context save/restore engine
// Options: MGT_01_FREG_CTX_FCSR_EN streams an extra fcsr word at base + FREG_CTX_FCSR_OFFSET.
module mgt_01_freg_context_unit
  import mgt_01_freg_context_unit_pkg::*;
#(
  parameter int N_FREG     = 32,
  parameter int WORD_BYTES = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 clk_en_i,
  input  logic                 save_req_i,
  input  logic                 restore_req_i,
  input  logic [31:0]          base_addr_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [31:0]          mem_addr_o,
  output logic [31:0]          mem_wdata_o,
  input  logic                 mem_gnt_i,
  input  logic                 mem_rvalid_i,
  input  logic [31:0]          mem_rdata_i,
  input  float_t [N_FREG-1:0]  freg_file_snap_i,
  output float_t [N_FREG-1:0]  freg_file_load_o,
  output logic                 freg_load_we_o
`ifdef MGT_01_FREG_CTX_FCSR_EN
  ,
  input  logic [7:0]           fcsr_i,
  output logic [7:0]           fcsr_o,
  output logic                 fcsr_we_o
`endif
);

  localparam int CTX_WORDS = N_FREG + (FREG_CTX_WORDS - XLEN);
  localparam int IDX_W     = $clog2(CTX_WORDS);
  localparam int BUF_IDX_W = $clog2(N_FREG);

  ctx_state_e             state_q, state_d;
  float_t [N_FREG-1:0]    ctx_buf_q;
  logic [IDX_W-1:0]       idx_q;
  logic [31:0]            base_q;
  logic [BUF_IDX_W-1:0]   buf_idx;
  logic                   last_word;
  logic [31:0]            cur_addr;
  logic [31:0]            cur_wdata;

  assign buf_idx   = idx_q[BUF_IDX_W-1:0];
  assign last_word = (idx_q == IDX_W'(CTX_WORDS - 1));

`ifdef MGT_01_FREG_CTX_FCSR_EN
  logic [7:0] fcsr_q;
  logic       fcsr_word;

  assign fcsr_word = (idx_q == IDX_W'(N_FREG));
  assign fcsr_o    = fcsr_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      fcsr_q <= '0;
    end else if (clk_en_i) begin
      if (state_q == ST_IDLE && save_req_i) begin
        fcsr_q <= fcsr_i;
      end else if (state_q == ST_LOAD_WAIT && mem_rvalid_i && fcsr_word) begin
        fcsr_q <= mem_rdata_i[7:0];
      end
    end
  end

  always_comb begin
    cur_addr  = base_q + (32'(idx_q) * 32'(WORD_BYTES));
    cur_wdata = ctx_buf_q[buf_idx];
    if (fcsr_word) begin
      cur_addr  = base_q + 32'(FREG_CTX_FCSR_OFFSET);
      cur_wdata = {24'b0, fcsr_q};
    end
  end
`else
  assign cur_addr  = base_q + (32'(idx_q) * 32'(WORD_BYTES));
  assign cur_wdata = ctx_buf_q[buf_idx];
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      ctx_buf_q <= '0;
      idx_q     <= '0;
      base_q    <= '0;
    end else if (clk_en_i) begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (save_req_i) begin
            ctx_buf_q <= freg_file_snap_i;
            base_q    <= {base_addr_i[31:2], 2'b00};
            idx_q     <= '0;
          end else if (restore_req_i) begin
            base_q <= {base_addr_i[31:2], 2'b00};
            idx_q  <= '0;
          end
        end
        ST_SAVE_REQ: begin
          if (mem_gnt_i && !last_word) idx_q <= idx_q + IDX_W'(1);
        end
        ST_LOAD_WAIT: begin
          if (mem_rvalid_i) begin
`ifdef MGT_01_FREG_CTX_FCSR_EN
            if (!fcsr_word) ctx_buf_q[buf_idx] <= mem_rdata_i;
`else
            ctx_buf_q[buf_idx] <= mem_rdata_i;
`endif
            if (!last_word) idx_q <= idx_q + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // The register file only ever sees the buffer through the single COMMIT strobe.
  assign freg_file_load_o = ctx_buf_q;
  assign busy_o           = (state_q != ST_IDLE);

  always_comb begin
    state_d        = state_q;
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_addr_o     = '0;
    mem_wdata_o    = '0;
    freg_load_we_o = 1'b0;
    done_o         = 1'b0;
`ifdef MGT_01_FREG_CTX_FCSR_EN
    fcsr_we_o      = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (save_req_i)         state_d = ST_SAVE_REQ;
        else if (restore_req_i) state_d = ST_LOAD_REQ;
      end
      ST_SAVE_REQ: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = cur_addr;
        mem_wdata_o = cur_wdata;
        if (mem_gnt_i && last_word) state_d = ST_DONE;
      end
      ST_LOAD_REQ: begin
        mem_req_o  = 1'b1;
        mem_addr_o = cur_addr;
        if (mem_gnt_i) state_d = ST_LOAD_WAIT;
      end
      ST_LOAD_WAIT: begin
        if (mem_rvalid_i) state_d = last_word ? ST_COMMIT : ST_LOAD_REQ;
      end
      ST_COMMIT: begin
        freg_load_we_o = 1'b1;
`ifdef MGT_01_FREG_CTX_FCSR_EN
        fcsr_we_o      = 1'b1;
`endif
        state_d        = ST_DONE;
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
